// File: rtl/vga_timing_pkg.sv
// Shared constants for the 800x480 raster generator: default timing, derived
// totals and the counter width used by the timing block and its interface.
package vga_timing_pkg;

  localparam int CNT_W = 11;
  localparam int PIX_W = 24;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FRONT_DEF  = 40;
  localparam int H_SYNC_DEF   = 128;
  localparam int H_BACK_DEF   = 88;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 13;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BACK_DEF   = 29;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Half-open window test [lo, hi) on a counter value.
  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Bundle of the raster timing signals between the timing generator (master)
// and the compositor/panel side (slave).
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic             line_start;
  logic             frame_start;
  logic             hs;
  logic             vs;
  logic             de;
  logic [PIX_W-1:0] rgb;
  logic [PIX_W-1:0] pixel;

  // No handshake: every signal is valid on every pixel clock; there is no
  // ready/stall path, the raster free-runs.
  modport master (output h, v, line_start, frame_start, hs, vs, de, rgb,
                  input  pixel);
  modport slave  (input  h, v, line_start, frame_start, hs, vs, de, rgb,
                  output pixel);
endinterface

// File: rtl/vga_delay_line.sv
// Width x depth shift register with synchronous reset to a fixed value; used to
// match sync/de to the compositor's pixel latency.
module vga_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: free-running h/v counters, decoded sync/de delayed
// to the compositor latency, and a registered blanked RGB/sync output stage.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int PIPE_DELAY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pixel_in,
  output logic [CNT_W-1:0] vga_h,
  output logic [CNT_W-1:0] vga_v,
  output logic             line_start,
  output logic             frame_start,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [PIX_W-1:0] vga_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic       raw_hs, raw_vs, raw_de;
  logic [2:0] dly_q;
  logic       d_hs, d_vs, d_de;

  always_ff @(posedge clk) begin
    if (reset) begin
      vga_h <= '0;
      vga_v <= '0;
    end else if (vga_h == H_LAST) begin
      vga_h <= '0;
      vga_v <= (vga_v == V_LAST) ? '0 : vga_v + CNT_W'(1);
    end else begin
      vga_h <= vga_h + CNT_W'(1);
    end
  end

  assign line_start  = (vga_h == '0);
  assign frame_start = (vga_h == '0) && (vga_v == '0);

  // Internally sync/de are active-high; panel polarity is only applied at the pins.
  assign raw_de = (vga_h < H_ACT) && (vga_v < V_ACT);
  assign raw_hs = in_window(vga_h, HS_START, HS_END);
  assign raw_vs = in_window(vga_v, VS_START, VS_END);

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (3'b000)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .d     ({raw_hs, raw_vs, raw_de}),
    .q     (dly_q)
  );

  assign {d_hs, d_vs, d_de} = dly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vga_hs  <= ~HS_POL;
      vga_vs  <= ~VS_POL;
      vga_de  <= 1'b0;
      vga_rgb <= '0;
    end else begin
      vga_hs  <= d_hs ? HS_POL : ~HS_POL;
      vga_vs  <= d_vs ? VS_POL : ~VS_POL;
      vga_de  <= d_de;
      vga_rgb <= d_de ? pixel_in : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a vector table on a default-width-line instance plus
// reduced-raster instances for latency, polarity and blanking corner cases.
module tb_vga_timing;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   ka = 0;
  int   kb = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  initial forever #5 clk = ~clk;

  // Cycles since reset release, per reset domain (0 = first clock after release).
  always @(posedge clk) ka <= rst_a ? 0 : ka + 1;
  always @(posedge clk) kb <= rst_b ? 0 : kb + 1;

  vga_timing_if if_a ();
  vga_timing_if if_b ();
  vga_timing_if if_c ();
  vga_timing_if if_d ();

  vga_timing #(.V_ACTIVE(4), .V_FRONT(2), .V_SYNC(3), .V_BACK(2), .PIPE_DELAY(2)) dut_a (
    .clk(clk), .reset(rst_a), .pixel_in(if_a.pixel), .vga_h(if_a.h), .vga_v(if_a.v),
    .line_start(if_a.line_start), .frame_start(if_a.frame_start), .vga_hs(if_a.hs),
    .vga_vs(if_a.vs), .vga_de(if_a.de), .vga_rgb(if_a.rgb));

  vga_timing #(.H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6), .V_ACTIVE(8),
               .V_FRONT(2), .V_SYNC(3), .V_BACK(3), .PIPE_DELAY(1)) dut_b (
    .clk(clk), .reset(rst_b), .pixel_in(if_b.pixel), .vga_h(if_b.h), .vga_v(if_b.v),
    .line_start(if_b.line_start), .frame_start(if_b.frame_start), .vga_hs(if_b.hs),
    .vga_vs(if_b.vs), .vga_de(if_b.de), .vga_rgb(if_b.rgb));

  vga_timing #(.H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6), .V_ACTIVE(8),
               .V_FRONT(2), .V_SYNC(3), .V_BACK(3), .PIPE_DELAY(4)) dut_c (
    .clk(clk), .reset(rst_b), .pixel_in(if_c.pixel), .vga_h(if_c.h), .vga_v(if_c.v),
    .line_start(if_c.line_start), .frame_start(if_c.frame_start), .vga_hs(if_c.hs),
    .vga_vs(if_c.vs), .vga_de(if_c.de), .vga_rgb(if_c.rgb));

  vga_timing #(.H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6), .V_ACTIVE(8),
               .V_FRONT(2), .V_SYNC(3), .V_BACK(3), .HS_POL(1'b1), .VS_POL(1'b1),
               .PIPE_DELAY(2)) dut_d (
    .clk(clk), .reset(rst_b), .pixel_in(if_d.pixel), .vga_h(if_d.h), .vga_v(if_d.v),
    .line_start(if_d.line_start), .frame_start(if_d.frame_start), .vga_hs(if_d.hs),
    .vga_vs(if_d.vs), .vga_de(if_d.de), .vga_rgb(if_d.rgb));

  // Compositor stand-in: pixel carries the {v,h} it was computed from, PIPE_DELAY late.
  logic [21:0] hist_a [2];
  logic [21:0] hist_b [1];
  logic [21:0] hist_c [4];

  always @(posedge clk) begin
    hist_a[0] <= {if_a.v, if_a.h};
    hist_a[1] <= hist_a[0];
    hist_b[0] <= {if_b.v, if_b.h};
    hist_c[0] <= {if_c.v, if_c.h};
    for (int i = 1; i < 4; i++) hist_c[i] <= hist_c[i-1];
  end

  assign if_a.pixel = {2'b00, hist_a[1]};
  assign if_b.pixel = {2'b00, hist_b[0]};
  assign if_c.pixel = {2'b00, hist_c[3]};
  assign if_d.pixel = 24'hFFFFFF;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, required %0h", name, idx, act, want);
    end
  endtask

  task automatic wait_ka(input int target);
    int guard = 0;
    while (ka != target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (ka != target) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_ka: got cycle %0d, required %0d", ka, target);
    end
  endtask

  // frame_start / line_start occurrences inside the first frame of dut_a.
  int fs_cnt = 0;
  int ls_cnt = 0;
  bit fs_done = 1'b0;
  always @(negedge clk) begin
    if (!fs_done && ka >= 1) begin
      if (if_a.frame_start) fs_cnt++;
      if (if_a.line_start) ls_cnt++;
      if (ka == 11615) fs_done = 1'b1;
    end
  end

  // First / last data-enable of frame 0 on the PIPE_DELAY=1 (0) and =4 (1) instances.
  int          first_k [2];
  int          last_k [2];
  logic [23:0] first_rgb [2];
  logic [23:0] last_rgb [2];
  bit          seen [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    if (kb >= 1 && kb < 512) begin
      if (if_b.de && !seen[0]) begin seen[0] = 1'b1; first_k[0] = kb; first_rgb[0] = if_b.rgb; end
      if (if_c.de && !seen[1]) begin seen[1] = 1'b1; first_k[1] = kb; first_rgb[1] = if_c.rgb; end
      if (if_b.de) begin last_k[0] = kb; last_rgb[0] = if_b.rgb; end
      if (if_c.de) begin last_k[1] = kb; last_rgb[1] = if_c.rgb; end
    end
  end

  // Blanking and active-high polarity over one full output frame of dut_d.
  int d_de_cnt = 0, d_hs_cnt = 0, d_vs_cnt = 0, d_rgb_bad = 0;
  always @(negedge clk) begin
    if (kb >= 3 && kb < 515) begin
      if (if_d.de === 1'b1) d_de_cnt++;
      if (if_d.hs === 1'b1) d_hs_cnt++;
      if (if_d.vs === 1'b1) d_vs_cnt++;
      if ((if_d.de === 1'b1 && if_d.rgb !== 24'hFFFFFF) ||
          (if_d.de !== 1'b1 && if_d.rgb !== 24'h000000)) d_rgb_bad++;
    end
  end

  typedef struct {
    int          k;
    logic [10:0] h;
    logic [10:0] v;
    logic [4:0]  flags;  // {line_start, frame_start, hs, vs, de}
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs [24];

  initial begin
    int hs_bad, de_cnt, de_early;

    vecs[0]  = '{0,     0,    0,  5'b11110, 24'd0};
    vecs[1]  = '{1,     1,    0,  5'b00110, 24'd0};
    vecs[2]  = '{3,     3,    0,  5'b00111, 24'd0};
    vecs[3]  = '{4,     4,    0,  5'b00111, 24'd1};
    vecs[4]  = '{802,   802,  0,  5'b00111, 24'd799};
    vecs[5]  = '{803,   803,  0,  5'b00110, 24'd0};
    vecs[6]  = '{842,   842,  0,  5'b00110, 24'd0};
    vecs[7]  = '{843,   843,  0,  5'b00010, 24'd0};
    vecs[8]  = '{970,   970,  0,  5'b00010, 24'd0};
    vecs[9]  = '{971,   971,  0,  5'b00110, 24'd0};
    vecs[10] = '{1055,  1055, 0,  5'b00110, 24'd0};
    vecs[11] = '{1056,  0,    1,  5'b10110, 24'd0};
    vecs[12] = '{1059,  3,    1,  5'b00111, 24'd2048};
    vecs[13] = '{3970,  802,  3,  5'b00111, 24'd6943};
    vecs[14] = '{3971,  803,  3,  5'b00110, 24'd0};
    vecs[15] = '{4227,  3,    4,  5'b00110, 24'd0};
    vecs[16] = '{6338,  2,    6,  5'b00110, 24'd0};
    vecs[17] = '{6339,  3,    6,  5'b00100, 24'd0};
    vecs[18] = '{7179,  843,  6,  5'b00000, 24'd0};
    vecs[19] = '{9506,  2,    9,  5'b00100, 24'd0};
    vecs[20] = '{9507,  3,    9,  5'b00110, 24'd0};
    vecs[21] = '{11615, 1055, 10, 5'b00110, 24'd0};
    vecs[22] = '{11616, 0,    0,  5'b11110, 24'd0};
    vecs[23] = '{11619, 3,    0,  5'b00111, 24'd0};

    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_h", i, 32'(if_a.h), 32'd0);
      check("rst_v", i, 32'(if_a.v), 32'd0);
      check("rst_flags", i, {if_a.line_start, if_a.frame_start, if_a.hs, if_a.vs, if_a.de}, 5'b11110);
      check("rst_rgb", i, if_a.rgb, 24'd0);
      check("rst_pol_d", i, {if_d.hs, if_d.vs, if_d.de}, 3'b000);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int i = 0; i < 24; i++) begin
      wait_ka(vecs[i].k);
      check("vec_h", i, 32'(if_a.h), 32'(vecs[i].h));
      check("vec_v", i, 32'(if_a.v), 32'(vecs[i].v));
      check("vec_flags", i, {if_a.line_start, if_a.frame_start, if_a.hs, if_a.vs, if_a.de},
            32'(vecs[i].flags));
      check("vec_rgb", i, if_a.rgb, vecs[i].rgb);
    end

    check("fs_count_frame0", 0, fs_cnt, 0);
    check("ls_count_frame0", 0, ls_cnt, 10);

    // One-clock reset at (900,1) of frame 1 while hs is being driven active.
    wait_ka(11616 + 1056 + 900);
    check("mid_pre_h", 0, 32'(if_a.h), 32'd900);
    check("mid_pre_hs", 0, if_a.hs, 1'b0);
    rst_a = 1'b1;
    @(negedge clk);
    check("mid_rst_hv", 0, {if_a.v, if_a.h}, 22'd0);
    check("mid_rst_flags", 0, {if_a.frame_start, if_a.hs, if_a.vs, if_a.de}, 4'b1110);
    rst_a = 1'b0;
    hs_bad = 0;
    de_cnt = 0;
    de_early = 0;
    for (int k = 1; k < 843; k++) begin
      @(negedge clk);
      if (if_a.hs !== 1'b1) hs_bad++;
      if (if_a.de === 1'b1) de_cnt++;
      if (k < 3 && if_a.de !== 1'b0) de_early++;
    end
    check("mid_hs_inactive", 0, hs_bad, 0);
    check("mid_de_early", 0, de_early, 0);
    check("mid_de_count", 0, de_cnt, 800);
    @(negedge clk);
    check("mid_hs_at_840", 0, if_a.hs, 1'b0);
    check("mid_h_at_840", 0, 32'(if_a.h), 32'd843);

    check("pd1_first_k", 0, first_k[0], 2);
    check("pd1_first_rgb", 0, first_rgb[0], 24'd0);
    check("pd1_last_k", 0, last_k[0], 241);
    check("pd1_last_rgb", 0, last_rgb[0], 24'd14351);
    check("pd4_first_k", 0, first_k[1], 5);
    check("pd4_first_rgb", 0, first_rgb[1], 24'd0);
    check("pd4_last_k", 0, last_k[1], 244);
    check("pd4_last_rgb", 0, last_rgb[1], 24'd14351);

    check("blank_de_count", 0, d_de_cnt, 128);
    check("blank_hs_count", 0, d_hs_cnt, 96);
    check("blank_vs_count", 0, d_vs_cnt, 96);
    check("blank_rgb_bad", 0, d_rgb_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
